pdp8lptrfeed: RTL and testbench
===============================

# pdp8lptrfeed

Paper-tape feeder that sits directly upstream of the PDP-8/L paper tape reader interface. The ARM pushes tape bytes into a 16-deep FIFO. The feeder answers the reader interface's step requests at a programmable pace that emulates real reader speed. After each pacing delay it delivers one byte with a load strobe. The ARM no longer has to hand-time each reader character.

## Interface
- No parameters; FIFO depth fixed at 16, pace counter width fixed at 20 bits.
- CLOCK  in  1  system clock
- RESET  in  1  reset RESET, synchronous, active-high; clock CLOCK
- armwrite  in  1  ARM register write strobe, one cycle
- armraddr  in  2  ARM read register index
- armwaddr  in  2  ARM write register index
- armwdata  in  32  ARM write data
- armrdata  out  32  ARM read data, combinational from armraddr
- stepreq  in  1  level from reader interface: reader wants next char
- stepack  out  1  one-cycle pulse: step accepted; reader interface clears its step request on it
- ldstrobe  out  1  one-cycle pulse: lddata valid, reader interface latches it and sets its ready flag
- lddata  out  8  tape byte; holds last delivered value between strobes

## Operation
- Reg [0] read: 32'h50461001 ('PF', sizecode 1, version 001). Writes ignored.
- Reg [1] write: push armwdata[7:0] into the FIFO if count<16. If full, drop the byte and set ovf (sticky).
- Reg [1] read layout:
  - [31] full, [30] empty, [29] ovf
  - [28] busy (state≠IDLE)
  - [20:16] count 0..16
  - [7:0] FIFO head; 0 when empty
  - All other bits 0.
- Reg [2] write/read: [19:0] pace, the cycles of delay per char. Other bits 0.
- Reg [3] write bits:
  - [0] enable, stored.
  - [1] flush, self-clearing: empties the FIFO (count=0, pointers=0) and forces IDLE with no strobe.
  - [2] clear ovf.
- Reg [3] read: [0] enable; others 0.
- FIFO: 16×8, 4-bit read/write pointers wrap modulo 16, 5-bit count.
- Push and pop in the same cycle: both succeed, count unchanged. Full is judged before the pop, so a push while full is rejected even if a pop occurs that cycle.
- FSM states IDLE, WAIT:
  - IDLE → WAIT when enable & stepreq & !empty. On that transition: stepack<=1, cnt<=pace.
  - IDLE with stepreq & empty: stay IDLE, no stepack. The reader sees tape-out and keeps waiting. Service starts automatically when a byte arrives.
  - WAIT, cnt≠0: cnt<=cnt-1.
  - WAIT, cnt==0: ldstrobe<=1, lddata<=head, pop, → IDLE.
  - WAIT with enable=0 (cleared mid-wait): → IDLE, no pop, no strobe. The step is lost; the reader must re-request.
  - Flush overrides every FSM action in its cycle.
- The FIFO cannot empty during WAIT except by flush, since only the FSM pops.
- stepreq still high in IDLE after a delivery starts a new step. This is legal back-to-back behaviour.

## Timing
- Reset values:
  - stepack=0, ldstrobe=0, lddata=0
  - state IDLE, cnt=0
  - FIFO empty, ovf=0, enable=0, pace=0
- RESET overrides armwrite in the same cycle.
- Cycle 0: stepreq sampled high in IDLE with the condition true.
- Cycle 1: stepack high (exactly one cycle); state WAIT, cnt=P.
- Cycle 2+P: ldstrobe high for one cycle with lddata valid. With P=0, ldstrobe is in cycle 2.
- Count and empty reflect a pop from cycle 2+P onward. An ARM read in cycle 2+P sees the new head.
- Step-to-step minimum period with stepreq held high: P+2 cycles.
- ARM push is visible in count/head on the cycle after armwrite.
- A push into an empty FIFO while stepreq is held can start a step one cycle after the push.

## Test plan
- Reset, read reg0 → 32'h50461001; reg1 → empty=1, count=0, ovf=0; reg3 → 0.
- Push 0x80,0x41,0x42; pace=3; enable=1; pulse stepreq → stepack in cycle 1, ldstrobe in cycle 5 with lddata=0x80; then count=2, head=0x41.
- Push 17 bytes → full=1 after 16, ovf=1, 17th byte dropped. Drain all 16 in order with pace=0; ldstrobes spaced 2 cycles apart with stepreq held. Write reg3 bit2 → ovf=0.
- Empty FIFO, enable=1, stepreq held → no stepack. Push 0x55 → stepack one cycle later, ldstrobe with 0x55 two cycles after that (pace=0).
- pace=100, step started; at cnt=50 write reg3=0 → IDLE, no ldstrobe, count unchanged. Repeat with flush (reg3=3) → count=0, no ldstrobe.
- FIFO at count 16 with pop cycle coinciding with push → push rejected, ovf=1, count=15. At count 5 with simultaneous push+pop → count stays 5, order preserved across pointer wrap.

Source files
------------

// File: rtl/pdp8lptrfeed.sv
// Paper-tape feeder for the PDP-8/L reader interface: ARM-filled 16-byte FIFO,
// delivering one byte per reader step request after a programmable pace delay.
module pdp8lptrfeed (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        stepreq,
  output logic        stepack,
  output logic        ldstrobe,
  output logic [7:0]  lddata
);

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PTR_W  = 4;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned PACE_W = 20;
  localparam int unsigned DATA_W = 8;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [PACE_W-1:0]   cnt_q, cnt_d;
  logic [PACE_W-1:0]   pace_q, pace_d;
  logic                enable_q, enable_d;
  logic                ovf_q, ovf_d;
  logic                stepack_q, stepack_d;
  logic                ldstrobe_q, ldstrobe_d;
  logic [DATA_W-1:0]   lddata_q, lddata_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                full, empty, wr_fifo, push_ok, flush, pop;
  logic [DATA_W-1:0]   head;
  logic                unused_wdata;

  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign head         = empty ? '0 : mem_q[rptr_q];
  assign wr_fifo      = armwrite && (armwaddr == 2'd1);
  assign push_ok      = wr_fifo && !full;
  assign flush        = armwrite && (armwaddr == 2'd3) && armwdata[1];
  assign unused_wdata = ^armwdata[31:PACE_W];

  assign stepack  = stepack_q;
  assign ldstrobe = ldstrobe_q;
  assign lddata   = lddata_q;

  // State and control registers
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pace_q     <= '0;
      enable_q   <= 1'b0;
      ovf_q      <= 1'b0;
      stepack_q  <= 1'b0;
      ldstrobe_q <= 1'b0;
      lddata_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pace_q     <= pace_d;
      enable_q   <= enable_d;
      ovf_q      <= ovf_d;
      stepack_q  <= stepack_d;
      ldstrobe_q <= ldstrobe_d;
      lddata_q   <= lddata_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage needs no reset; count gates every read
  always_ff @(posedge CLOCK) begin
    if (push_ok && !RESET) mem_q[wptr_q] <= armwdata[DATA_W-1:0];
  end

  // Next-state: pacing FSM, then flush override, then register writes and FIFO pointers
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stepack_d  = 1'b0;
    ldstrobe_d = 1'b0;
    lddata_d   = lddata_q;
    pop        = 1'b0;
    pace_d     = pace_q;
    enable_d   = enable_q;
    ovf_d      = ovf_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;

    case (state_q)
      IDLE: begin
        if (enable_q && stepreq && !empty) begin
          state_d   = WAIT;
          stepack_d = 1'b1;
          cnt_d     = pace_q;
        end
      end
      WAIT: begin
        if (!enable_q) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          ldstrobe_d = 1'b1;
          lddata_d   = head;
          pop        = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - PACE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d    = IDLE;
      cnt_d      = '0;
      stepack_d  = 1'b0;
      ldstrobe_d = 1'b0;
      lddata_d   = lddata_q;
      pop        = 1'b0;
    end

    if (armwrite && (armwaddr == 2'd2)) pace_d = armwdata[PACE_W-1:0];
    if (armwrite && (armwaddr == 2'd3)) begin
      enable_d = armwdata[0];
      if (armwdata[2]) ovf_d = 1'b0;
    end
    if (wr_fifo && full) ovf_d = 1'b1;

    if (push_ok) wptr_d = wptr_q + PTR_W'(1);
    if (pop)     rptr_d = rptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  // ARM register read mux
  always_comb begin
    armrdata = '0;
    case (armraddr)
      2'd0: armrdata = 32'h5046_1001;
      2'd1: begin
        armrdata[31]    = full;
        armrdata[30]    = empty;
        armrdata[29]    = ovf_q;
        armrdata[28]    = (state_q != IDLE);
        armrdata[20:16] = count_q;
        armrdata[7:0]   = head;
      end
      2'd2: armrdata[PACE_W-1:0] = pace_q;
      2'd3: armrdata[0] = enable_q;
      default: armrdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pdp8lptrfeed.sv
// Directed self-checking bench for the pdp8lptrfeed paper-tape feeder.
module tb_pdp8lptrfeed;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        armwrite;
  logic [1:0]  armraddr;
  logic [1:0]  armwaddr;
  logic [31:0] armwdata;
  logic [31:0] armrdata;
  logic        stepreq;
  logic        stepack;
  logic        ldstrobe;
  logic [7:0]  lddata;

  int passed = 0;
  int total  = 0;

  pdp8lptrfeed dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .armwrite (armwrite),
    .armraddr (armraddr),
    .armwaddr (armwaddr),
    .armwdata (armwdata),
    .armrdata (armrdata),
    .stepreq  (stepreq),
    .stepack  (stepack),
    .ldstrobe (ldstrobe),
    .lddata   (lddata)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // One-cycle ARM write; returns one cycle later
  task automatic arm_write(input logic [1:0] addr, input logic [31:0] data);
    armwrite = 1'b1;
    armwaddr = addr;
    armwdata = data;
    tick();
    armwrite = 1'b0;
    armwdata = '0;
  endtask

  task automatic arm_read(input logic [1:0] addr, output logic [31:0] data);
    armraddr = addr;
    #1;
    data = armrdata;
  endtask

  // Single step: stepreq for one cycle, return outputs seen in cycle 2 (pace 0)
  task automatic do_step(output logic strobe, output logic [7:0] data);
    stepreq = 1'b1;
    tick();
    stepreq = 1'b0;
    tick();
    strobe = ldstrobe;
    data   = lddata;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    RESET = 1'b1;
    arm_write(2'd2, 32'd5);
    tick();
    RESET = 1'b0;
    arm_read(2'd0, r);
    total++; if (r !== 32'h5046_1001) $display("FAIL reset_reg0 got=%h exp=%h", r, 32'h5046_1001); else passed++;
    arm_read(2'd1, r);
    total++; if (r !== 32'h4000_0000) $display("FAIL reset_reg1 got=%h exp=%h", r, 32'h4000_0000); else passed++;
    arm_read(2'd2, r);
    total++; if (r !== 32'h0) $display("FAIL reset_pace got=%h exp=0", r); else passed++;
    arm_read(2'd3, r);
    total++; if (r !== 32'h0) $display("FAIL reset_reg3 got=%h exp=0", r); else passed++;
    total++;
    if ({stepack, ldstrobe, lddata} !== 10'h0) $display("FAIL reset_outputs got=%h exp=0", {stepack, ldstrobe, lddata});
    else passed++;
  endtask

  task automatic test_basic_step();
    logic [31:0] r;
    int early;
    arm_write(2'd1, 32'h80);
    arm_write(2'd1, 32'h41);
    arm_write(2'd1, 32'h42);
    arm_write(2'd2, 32'd3);
    arm_write(2'd3, 32'd1);
    stepreq = 1'b1;
    tick();
    stepreq = 1'b0;
    total++; if (stepack !== 1'b1) $display("FAIL basic_stepack got=%b exp=1", stepack); else passed++;
    early = 0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      if (ldstrobe !== 1'b0 || stepack !== 1'b0) early++;
    end
    total++; if (early !== 0) $display("FAIL basic_early_pulse got=%0d exp=0", early); else passed++;
    tick();
    total++;
    if (ldstrobe !== 1'b1 || lddata !== 8'h80) $display("FAIL basic_strobe got=%b/%h exp=1/80", ldstrobe, lddata);
    else passed++;
    arm_read(2'd1, r);
    total++; if (r !== 32'h0002_0041) $display("FAIL basic_reg1 got=%h exp=%h", r, 32'h0002_0041); else passed++;
    tick();
    total++;
    if (ldstrobe !== 1'b0 || lddata !== 8'h80) $display("FAIL basic_hold got=%b/%h exp=0/80", ldstrobe, lddata);
    else passed++;
  endtask

  task automatic test_overflow_drain();
    logic [31:0] r;
    int got, last;
    logic [7:0] exp_d;
    arm_write(2'd3, 32'd2);
    for (int i = 0; i < 16; i++) arm_write(2'd1, 32'(8'h10 + i));
    arm_read(2'd1, r);
    total++; if (r !== 32'h8010_0010) $display("FAIL ovf_full got=%h exp=%h", r, 32'h8010_0010); else passed++;
    arm_write(2'd1, 32'hFF);
    arm_read(2'd1, r);
    total++; if (r !== 32'hA010_0010) $display("FAIL ovf_set got=%h exp=%h", r, 32'hA010_0010); else passed++;
    arm_write(2'd2, 32'd0);
    stepreq = 1'b1;
    arm_write(2'd3, 32'd1);
    got = 0;
    last = 0;
    for (int c = 0; c < 200 && got < 16; c++) begin
      tick();
      if (ldstrobe === 1'b1) begin
        exp_d = 8'h10 + 8'(got);
        total++;
        if (lddata !== exp_d) $display("FAIL drain_data idx=%0d got=%h exp=%h", got, lddata, exp_d);
        else passed++;
        if (got > 0) begin
          total++;
          if (c - last !== 2) $display("FAIL drain_spacing idx=%0d got=%0d exp=2", got, c - last);
          else passed++;
        end
        last = c;
        got++;
      end
    end
    total++; if (got !== 16) $display("FAIL drain_count got=%0d exp=16", got); else passed++;
    tick();
    tick();
    stepreq = 1'b0;
    arm_read(2'd1, r);
    total++; if (r !== 32'h6000_0000) $display("FAIL drain_empty got=%h exp=%h", r, 32'h6000_0000); else passed++;
    arm_write(2'd3, 32'd5);
    arm_read(2'd1, r);
    total++; if (r !== 32'h4000_0000) $display("FAIL ovf_clear got=%h exp=%h", r, 32'h4000_0000); else passed++;
  endtask

  task automatic test_tapeout();
    logic [31:0] r;
    int acks;
    stepreq = 1'b1;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (stepack !== 1'b0) acks++;
    end
    total++; if (acks !== 0) $display("FAIL tapeout_noack got=%0d exp=0", acks); else passed++;
    arm_write(2'd1, 32'h55);
    arm_read(2'd1, r);
    total++;
    if (r !== 32'h0001_0055 || stepack !== 1'b0) $display("FAIL tapeout_push got=%h/%b exp=%h/0", r, stepack, 32'h0001_0055);
    else passed++;
    tick();
    stepreq = 1'b0;
    total++; if (stepack !== 1'b1) $display("FAIL tapeout_ack got=%b exp=1", stepack); else passed++;
    tick();
    total++;
    if (ldstrobe !== 1'b1 || lddata !== 8'h55) $display("FAIL tapeout_strobe got=%b/%h exp=1/55", ldstrobe, lddata);
    else passed++;
  endtask

  task automatic test_abort();
    logic [31:0] r;
    int strobes;
    arm_write(2'd2, 32'd100);
    arm_write(2'd1, 32'h11);
    arm_write(2'd1, 32'h22);
    stepreq = 1'b1;
    tick();
    stepreq = 1'b0;
    total++; if (stepack !== 1'b1) $display("FAIL abort_ack got=%b exp=1", stepack); else passed++;
    arm_read(2'd1, r);
    total++; if (r !== 32'h1002_0011) $display("FAIL abort_busy got=%h exp=%h", r, 32'h1002_0011); else passed++;
    strobes = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (ldstrobe !== 1'b0) strobes++;
    end
    arm_write(2'd3, 32'd0);
    for (int c = 0; c < 150; c++) begin
      tick();
      if (ldstrobe !== 1'b0 || stepack !== 1'b0) strobes++;
    end
    total++; if (strobes !== 0) $display("FAIL abort_disable_pulses got=%0d exp=0", strobes); else passed++;
    arm_read(2'd1, r);
    total++; if (r !== 32'h0002_0011) $display("FAIL abort_disable_reg1 got=%h exp=%h", r, 32'h0002_0011); else passed++;

    arm_write(2'd3, 32'd1);
    stepreq = 1'b1;
    tick();
    stepreq = 1'b0;
    total++; if (stepack !== 1'b1) $display("FAIL flush_ack got=%b exp=1", stepack); else passed++;
    strobes = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (ldstrobe !== 1'b0) strobes++;
    end
    arm_write(2'd3, 32'd3);
    arm_read(2'd1, r);
    total++; if (r !== 32'h4000_0000) $display("FAIL flush_reg1 got=%h exp=%h", r, 32'h4000_0000); else passed++;
    for (int c = 0; c < 150; c++) begin
      tick();
      if (ldstrobe !== 1'b0 || stepack !== 1'b0) strobes++;
    end
    total++; if (strobes !== 0) $display("FAIL flush_pulses got=%0d exp=0", strobes); else passed++;
    arm_read(2'd3, r);
    total++; if (r !== 32'h1) $display("FAIL flush_enable got=%h exp=1", r); else passed++;
  endtask

  task automatic test_push_pop();
    logic [31:0] r;
    logic        s;
    logic [7:0]  d;
    logic [7:0]  exp_d;
    arm_write(2'd3, 32'd2);
    arm_write(2'd2, 32'd0);
    for (int i = 0; i < 16; i++) arm_write(2'd1, 32'(8'hA0 + i));
    arm_read(2'd1, r);
    total++; if (r !== 32'h8010_00A0) $display("FAIL pp_full got=%h exp=%h", r, 32'h8010_00A0); else passed++;
    arm_write(2'd3, 32'd1);
    stepreq = 1'b1;
    tick();
    stepreq = 1'b0;
    total++; if (stepack !== 1'b1) $display("FAIL pp_full_ack got=%b exp=1", stepack); else passed++;
    arm_write(2'd1, 32'hEE);
    total++;
    if (ldstrobe !== 1'b1 || lddata !== 8'hA0) $display("FAIL pp_full_strobe got=%b/%h exp=1/a0", ldstrobe, lddata);
    else passed++;
    arm_read(2'd1, r);
    total++; if (r !== 32'h200F_00A1) $display("FAIL pp_full_reject got=%h exp=%h", r, 32'h200F_00A1); else passed++;
    arm_write(2'd3, 32'd5);
    for (int i = 1; i <= 10; i++) begin
      do_step(s, d);
      exp_d = 8'hA0 + 8'(i);
      total++;
      if (s !== 1'b1 || d !== exp_d) $display("FAIL pp_drain idx=%0d got=%b/%h exp=1/%h", i, s, d, exp_d);
      else passed++;
    end
    arm_read(2'd1, r);
    total++; if (r !== 32'h0005_00AB) $display("FAIL pp_count5 got=%h exp=%h", r, 32'h0005_00AB); else passed++;
    stepreq = 1'b1;
    tick();
    stepreq = 1'b0;
    arm_write(2'd1, 32'hB0);
    total++;
    if (ldstrobe !== 1'b1 || lddata !== 8'hAB) $display("FAIL pp_simul_strobe got=%b/%h exp=1/ab", ldstrobe, lddata);
    else passed++;
    arm_read(2'd1, r);
    total++; if (r !== 32'h0005_00AC) $display("FAIL pp_simul_count got=%h exp=%h", r, 32'h0005_00AC); else passed++;
    for (int i = 0; i < 5; i++) begin
      do_step(s, d);
      exp_d = 8'hAC + 8'(i);
      total++;
      if (s !== 1'b1 || d !== exp_d) $display("FAIL pp_wrap idx=%0d got=%b/%h exp=1/%h", i, s, d, exp_d);
      else passed++;
    end
    arm_read(2'd1, r);
    total++; if (r !== 32'h4000_0000) $display("FAIL pp_final got=%h exp=%h", r, 32'h4000_0000); else passed++;
  endtask

  initial begin
    RESET    = 1'b1;
    armwrite = 1'b0;
    armraddr = 2'd0;
    armwaddr = 2'd0;
    armwdata = '0;
    stepreq  = 1'b0;
    test_reset();
    test_basic_step();
    test_overflow_drain();
    test_tapeout();
    test_abort();
    test_push_pop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
